fifo_write_arbiter: RTL
=======================

// Module: fifo_write_arbiter
// PURPOSE
//  Shares the single 8-bit FIFO write port between NUM_REQ producers.
//  Uses round-robin grant with a per-grant burst limit, and tracks FIFO occupancy locally from write/read strobes.
//  Sits between the producers and the FIFO input side, replacing the single-producer write_en path.
//  Back-pressures producers when the FIFO is full; never issues an overflowing write.
// PARAMETERS
//  NUM_REQ    4   number of producers (>=2)
//  DATA_W     8   data word width
//  DEPTH      32  FIFO capacity in words; must match the FIFO instance
//  BURST_MAX  4   max words accepted per grant before forced rotation (>=1)
// PORTS
//  clk           in   1               rising-edge clock, sole clock domain
//  reset         in   1               synchronous, active-high reset
//  req           in   NUM_REQ         req[i]=1: producer i has a word on data_in slice i
//  data_in       in   NUM_REQ*DATA_W  producer i word at [i*DATA_W +: DATA_W]
//  fifo_rd_en    in   1               FIFO read strobe from consumer side (one word popped)
//  gnt           out  NUM_REQ         one-hot (or zero) current grant, registered
//  fifo_wr_en    out  1               write strobe to FIFO, combinational
//  fifo_wr_data  out  DATA_W          data_in slice of granted producer, combinational
//  count         out  clog2(DEPTH+1)  current occupancy, registered
//  full          out  1               count==DEPTH
//  empty         out  1               count==0
//  rd_err        out  1               sticky: fifo_rd_en seen while empty; cleared only by reset
// BEHAVIOUR
//  Reset (clk edge with reset=1):
//   - state=IDLE, gnt=0, count=0, burst_cnt=0, rd_err=0, last=NUM_REQ-1 (so req[0] wins first).
//   - Reset dominates every other input on that edge.
//  Accept rule: word from i accepted in a cycle iff state==GRANT && gnt[i] && req[i] && !full.
//   - fifo_wr_en = that condition; fifo_wr_data = data_in slice i.
//   - Zero-cycle latency; the producer advances its data on the next edge.
//  State IDLE:
//   - If |req, pick the first requester after `last` (circular). Next edge: gnt=onehot(pick), burst_cnt=0, GRANT.
//   - No write is issued in IDLE.
//  State GRANT (holder h):
//   - Accept -> burst_cnt+1.
//   - Rotation triggers (same edge):
//     - accept with burst_cnt==BURST_MAX-1;
//     - req[h]==0.
//   - On rotation: last=h; pick next requester after h excluding h-only-if-others-waiting.
//     - If another requester is waiting -> GRANT to it, burst_cnt=0, no idle bubble.
//     - Else if only h still requests -> re-grant h, burst_cnt=0.
//     - Else -> IDLE, gnt=0.
//   - While full: grant held, no accept, burst_cnt frozen; full alone never rotates.
//  Occupancy:
//   - count_next = count + wr - rd_eff, where rd_eff = fifo_rd_en && count!=0.
//   - Simultaneous wr and rd: count unchanged, write still accepted unless full.
//   - At count==DEPTH with fifo_rd_en=1: full blocks the write this cycle (no look-ahead); count-1 next cycle.
//   - fifo_rd_en at count==0: count stays 0, rd_err<=1.
//   - Arithmetic is unsigned, width clog2(DEPTH+1); never wraps by construction.
//  Fairness: any requester holding req continuously is granted within (NUM_REQ-1)*BURST_MAX accepted words.
//  Reset mid-burst: grant drops on that edge; the in-flight word of that cycle is not written (wr_en masked by reset).
// STRUCTURE
//  Package fifo_arb_pkg:
//   - state enum {IDLE, GRANT};
//   - CNT_W=clog2(DEPTH+1), IDX_W=clog2(NUM_REQ), BURST_W=clog2(BURST_MAX).
//  Sub-module rr_pick:
//   - combinational round-robin picker; inputs req, last; outputs onehot and idx.
//   - Used for both IDLE and rotation picks.
//  Top holds the FSM, burst counter, occupancy counter and the write mux.
// TESTING
//  1. reset=1 2 cycles, req=4'b1111 -> gnt=0, count=0, empty=1; release -> gnt=0001 next edge.
//  2. req=1111 held, no reads, BURST_MAX=4 -> grants 0,1,2,3 each 4 writes back-to-back; full=1 at count=32; wr_en=0 thereafter, gnt frozen.
//  3. Full, fifo_rd_en=1 one cycle, req held -> that cycle no write, count=31; next cycle write, count=32.
//  4. req=0010 only -> gnt=0010, 4 writes, re-grant 0010 with no bubble, continuous wr_en.
//  5. req[1] drops after 2 accepts while req[3]=1 -> gnt=1000 next edge, burst_cnt=0.
//  6. count=0, fifo_rd_en=1 -> count stays 0, rd_err=1 sticky; reset mid-GRANT with count=5 -> count=0, gnt=0, rd_err=0.

Source files
------------

// File: rtl/fifo_arb_pkg.sv
// Shared types and sizing helpers for the multi-producer FIFO write arbiter.
// Default-sized widths are provided; the top derives its own from its parameters.
package fifo_arb_pkg;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_e;

  // Bit width able to index n distinct values, never narrower than 1.
  function automatic int bits_for(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int DEF_NUM_REQ   = 4;
  localparam int DEF_DATA_W    = 8;
  localparam int DEF_DEPTH     = 32;
  localparam int DEF_BURST_MAX = 4;

  localparam int CNT_W   = bits_for(DEF_DEPTH + 1);
  localparam int IDX_W   = bits_for(DEF_NUM_REQ);
  localparam int BURST_W = bits_for(DEF_BURST_MAX);

endpackage

// File: rtl/fifo_write_arbiter_rr_pick.sv
// Combinational round-robin picker: first requester strictly after `last`,
// wrapping around so that `last` itself has the lowest priority.
module rr_pick #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   last,
  output logic [NUM_REQ-1:0] onehot,
  output logic [IDX_W-1:0]   idx,
  output logic               valid
);

  int cand;

  always_comb begin
    onehot = '0;
    idx    = '0;
    valid  = 1'b0;
    cand   = 0;
    for (int off = 1; off <= NUM_REQ; off++) begin
      cand = (int'(last) + off) % NUM_REQ;
      if (!valid && req[cand]) begin
        valid        = 1'b1;
        idx          = IDX_W'(cand);
        onehot[cand] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fifo_write_arbiter.sv
// Round-robin, burst-limited arbiter sharing one FIFO write port among
// NUM_REQ producers, with locally tracked occupancy and full back-pressure.
module fifo_write_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int NUM_REQ   = DEF_NUM_REQ,
  parameter int DATA_W    = DEF_DATA_W,
  parameter int DEPTH     = DEF_DEPTH,
  parameter int BURST_MAX = DEF_BURST_MAX
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [NUM_REQ-1:0]          req,
  input  logic [NUM_REQ*DATA_W-1:0]   data_in,
  input  logic                        fifo_rd_en,
  output logic [NUM_REQ-1:0]          gnt,
  output logic                        fifo_wr_en,
  output logic [DATA_W-1:0]           fifo_wr_data,
  output logic [bits_for(DEPTH+1)-1:0] count,
  output logic                        full,
  output logic                        empty,
  output logic                        rd_err
);

  localparam int CW = bits_for(DEPTH + 1);
  localparam int IW = bits_for(NUM_REQ);
  localparam int BW = bits_for(BURST_MAX);

  state_e             state_q, state_d;
  logic [NUM_REQ-1:0] gnt_q, gnt_d;
  logic [IW-1:0]      hold_q, hold_d;
  logic [IW-1:0]      last_q, last_d;
  logic [BW-1:0]      burst_q, burst_d;
  logic [CW-1:0]      count_q, count_d;
  logic               rd_err_q, rd_err_d;

  logic [DATA_W-1:0]  data_arr [NUM_REQ];
  logic [IW-1:0]      pick_last;
  logic [NUM_REQ-1:0] pick_onehot;
  logic [IW-1:0]      pick_idx;
  logic               pick_valid;
  logic               accept;
  logic               rd_eff;
  logic               rotate;

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
    assign data_arr[gi] = data_in[gi*DATA_W +: DATA_W];
  end

  assign full   = (count_q == CW'(DEPTH));
  assign empty  = (count_q == '0);
  assign count  = count_q;
  assign gnt    = gnt_q;
  assign rd_err = rd_err_q;

  // gnt_q is one-hot on hold_q whenever in GRANT, so gnt[i]&&req[i] reduces to req[hold].
  assign accept       = (state_q == GRANT) && req[hold_q] && !full;
  assign fifo_wr_en   = accept && !reset;
  assign fifo_wr_data = data_arr[hold_q];
  assign rd_eff       = fifo_rd_en && !empty;

  // The current holder is the rotation origin, so it only wins again when alone.
  assign pick_last = (state_q == GRANT) ? hold_q : last_q;

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IW)
  ) u_pick (
    .req    (req),
    .last   (pick_last),
    .onehot (pick_onehot),
    .idx    (pick_idx),
    .valid  (pick_valid)
  );

  always_comb begin
    count_d  = count_q + CW'(accept) - CW'(rd_eff);
    rd_err_d = rd_err_q | (fifo_rd_en && empty);
  end

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    hold_d  = hold_q;
    last_d  = last_q;
    burst_d = burst_q;
    rotate  = 1'b0;
    case (state_q)
      IDLE: begin
        if (pick_valid) begin
          state_d = GRANT;
          gnt_d   = pick_onehot;
          hold_d  = pick_idx;
          burst_d = '0;
        end
      end
      GRANT: begin
        if (accept) begin
          burst_d = burst_q + BW'(1);
        end
        rotate = (accept && (burst_q == BW'(BURST_MAX - 1))) || !req[hold_q];
        if (rotate) begin
          last_d  = hold_q;
          burst_d = '0;
          if (pick_valid) begin
            gnt_d  = pick_onehot;
            hold_d = pick_idx;
          end else begin
            state_d = IDLE;
            gnt_d   = '0;
          end
        end
      end
      default: begin
        state_d = IDLE;
        gnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      gnt_q    <= '0;
      hold_q   <= '0;
      last_q   <= IW'(NUM_REQ - 1);
      burst_q  <= '0;
      count_q  <= '0;
      rd_err_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      gnt_q    <= gnt_d;
      hold_q   <= hold_d;
      last_q   <= last_d;
      burst_q  <= burst_d;
      count_q  <= count_d;
      rd_err_q <= rd_err_d;
    end
  end

endmodule
